// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W           = 5;
  localparam int unsigned MEM_TIMEOUT_DEF = 256;

  typedef enum logic [1:0] {
    PC_RUN   = 2'd0,
    PC_MWAIT = 2'd1,
    PC_HALT  = 2'd2
  } pc_state_e;

  // Strobe bundle consumed by the pipeline registers.
  typedef struct packed {
    logic p_stall;
    logic f_stall;
    logic d_stall;
    logic e_stall;
    logic f_bubble;
    logic d_bubble;
    logic m_bubble;
  } strobe_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational hazard terms: memory wait, load-use interlock and mispredict.
module pipe_ctrl_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             use_rs1,
  input  logic             use_rs2,
  input  logic             ex_load,
  input  logic             ex_need_dst,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             ex_mispredict,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             mw_c,
  output logic             lu_c,
  output logic             mp_c
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = use_rs1 & (rs1 == ex_dst);
  assign rs2_hit = use_rs2 & (rs2 == ex_dst);

  assign mw_c = mem_req & ~mem_ready;
  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign lu_c = ex_load & ex_need_dst & (ex_dst != '0) & (rs1_hit | rs2_hit);
  assign mp_c = ex_mispredict;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard and sequencing controller: stall/bubble strobes, memory
// timeout watchdog and stall/flush performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TO_W        = 9
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic [REG_W-1:0] Dc_rs1_i,
  input  logic [REG_W-1:0] Dc_rs2_i,
  input  logic             Dc_use_rs1_i,
  input  logic             Dc_use_rs2_i,
  input  logic             Ex_load_i,
  input  logic             Ex_need_dstE_i,
  input  logic [REG_W-1:0] Ex_dstE_i,
  input  logic             Ex_mispredict_i,
  input  logic             M_mem_req_i,
  input  logic             M_mem_ready_i,
  output logic             P_stall_o,
  output logic             F_stall_o,
  output logic             D_stall_o,
  output logic             E_stall_o,
  output logic             F_bubble_o,
  output logic             D_bubble_o,
  output logic             M_bubble_o,
  output logic             halt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  pc_state_e       state;
  pc_state_e       state_next;
  logic [TO_W-1:0] to_cnt;
  logic            mw;
  logic            lu;
  logic            mp;
  logic            flush_take;
  strobe_t         str;

  pipe_ctrl_hazard_detect u_hazard (
    .rs1           (Dc_rs1_i),
    .rs2           (Dc_rs2_i),
    .use_rs1       (Dc_use_rs1_i),
    .use_rs2       (Dc_use_rs2_i),
    .ex_load       (Ex_load_i),
    .ex_need_dst   (Ex_need_dstE_i),
    .ex_dst        (Ex_dstE_i),
    .ex_mispredict (Ex_mispredict_i),
    .mem_req       (M_mem_req_i),
    .mem_ready     (M_mem_ready_i),
    .mw_c          (mw),
    .lu_c          (lu),
    .mp_c          (mp)
  );

  // State register
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) state <= PC_RUN;
    else     state <= state_next;
  end

  // Next-state logic; HALT is only left through reset.
  always_comb begin
    state_next = state;
    case (state)
      PC_RUN:   if (mw) state_next = PC_MWAIT;
      PC_MWAIT: begin
        if (!mw)                                  state_next = PC_RUN;
        else if (to_cnt == TO_W'(MEM_TIMEOUT - 1)) state_next = PC_HALT;
      end
      PC_HALT:  state_next = PC_HALT;
      default:  state_next = PC_RUN;
    endcase
  end

  // Strobe outputs, priority HALT > mw > mp > lu; a pending mispredict waits out mw.
  always_comb begin
    str        = '0;
    flush_take = 1'b0;
    if (rst) begin
      str.f_bubble = 1'b1;
      str.d_bubble = 1'b1;
      str.m_bubble = 1'b1;
    end else if (state == PC_HALT || mw) begin
      str.p_stall  = 1'b1;
      str.f_stall  = 1'b1;
      str.d_stall  = 1'b1;
      str.e_stall  = 1'b1;
      str.m_bubble = 1'b1;
    end else if (mp) begin
      str.f_bubble = 1'b1;
      str.d_bubble = 1'b1;
      flush_take   = 1'b1;
    end else if (lu) begin
      str.p_stall  = 1'b1;
      str.f_stall  = 1'b1;
      str.d_bubble = 1'b1;
    end
  end

  assign P_stall_o  = str.p_stall;
  assign F_stall_o  = str.f_stall;
  assign D_stall_o  = str.d_stall;
  assign E_stall_o  = str.e_stall;
  assign F_bubble_o = str.f_bubble;
  assign D_bubble_o = str.d_bubble;
  assign M_bubble_o = str.m_bubble;

  // Watchdog, sticky halt flag and wrapping performance counters.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      to_cnt      <= '0;
      halt_o      <= 1'b0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (state == PC_MWAIT && state_next == PC_MWAIT) to_cnt <= to_cnt + TO_W'(1);
      else                                             to_cnt <= '0;
      halt_o <= (state_next == PC_HALT);
      if (str.p_stall) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (flush_take)  flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a 32-bit counter build and a 4-bit counter
// build share stimulus; an independent model predicts strobes and counters.
module tb_pipe_ctrl;

  localparam int unsigned MT = 8;

  logic       clk_i = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2, dst;
  logic       use1, use2, ld, need, misp, req, rdy;

  logic       ps, fs, ds, es, fb, db, mb, halt;
  logic [31:0] scnt, fcnt;
  logic       ps4, fs4, ds4, es4, fb4, db4, mb4, halt4;
  logic [3:0] scnt4, fcnt4;

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] exp_q[$];

  // model state
  int          m_state;
  int          m_to;
  logic [31:0] m_stall, m_flush;
  logic        m_halt;

  always #5 clk_i = ~clk_i;

  pipe_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(32), .TO_W(4)) u_dut (
    .clk_i(clk_i), .rst(rst),
    .Dc_rs1_i(rs1), .Dc_rs2_i(rs2), .Dc_use_rs1_i(use1), .Dc_use_rs2_i(use2),
    .Ex_load_i(ld), .Ex_need_dstE_i(need), .Ex_dstE_i(dst), .Ex_mispredict_i(misp),
    .M_mem_req_i(req), .M_mem_ready_i(rdy),
    .P_stall_o(ps), .F_stall_o(fs), .D_stall_o(ds), .E_stall_o(es),
    .F_bubble_o(fb), .D_bubble_o(db), .M_bubble_o(mb),
    .halt_o(halt), .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
  );

  pipe_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(4), .TO_W(4)) u_dut4 (
    .clk_i(clk_i), .rst(rst),
    .Dc_rs1_i(rs1), .Dc_rs2_i(rs2), .Dc_use_rs1_i(use1), .Dc_use_rs2_i(use2),
    .Ex_load_i(ld), .Ex_need_dstE_i(need), .Ex_dstE_i(dst), .Ex_mispredict_i(misp),
    .M_mem_req_i(req), .M_mem_ready_i(rdy),
    .P_stall_o(ps4), .F_stall_o(fs4), .D_stall_o(ds4), .E_stall_o(es4),
    .F_bubble_o(fb4), .D_bubble_o(db4), .M_bubble_o(mb4),
    .halt_o(halt4), .stall_cnt_o(scnt4), .flush_cnt_o(fcnt4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    rs1 = 5'd0; rs2 = 5'd0; dst = 5'd0;
    use1 = 1'b0; use2 = 1'b0; ld = 1'b0; need = 1'b0;
    misp = 1'b0; req = 1'b0; rdy = 1'b0;
  endtask

  task automatic model_reset();
    m_state = 0; m_to = 0; m_stall = '0; m_flush = '0; m_halt = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".halt"},   32'(halt),   32'(m_halt));
    check({tag, ".scnt"},   scnt,        m_stall);
    check({tag, ".fcnt"},   fcnt,        m_flush);
    check({tag, ".halt4"},  32'(halt4),  32'(m_halt));
    check({tag, ".scnt4"},  32'(scnt4),  m_stall & 32'hF);
    check({tag, ".fcnt4"},  32'(fcnt4),  m_flush & 32'hF);
  endtask

  // One clock cycle: predict strobes from current inputs, check them mid-cycle,
  // advance the model, then check registered outputs after the edge.
  task automatic cycle(input string tag);
    logic       w, l, p;
    logic [6:0] e, got;
    w = req & ~rdy;
    l = ld & need & (dst != 5'd0) & ((use1 & (rs1 == dst)) | (use2 & (rs2 == dst)));
    p = misp;
    if (m_state == 2 || w) e = 7'b1111_001;
    else if (p)            e = 7'b0000_110;
    else if (l)            e = 7'b1100_010;
    else                   e = 7'b0000_000;
    exp_q.push_back(e);
    @(negedge clk_i);
    e = exp_q.pop_front();
    got = {ps, fs, ds, es, fb, db, mb};
    check({tag, ".strobes"}, 32'(got), 32'(e));
    got = {ps4, fs4, ds4, es4, fb4, db4, mb4};
    check({tag, ".strobes4"}, 32'(got), 32'(e));
    if (e[6]) m_stall = m_stall + 32'd1;
    if (m_state != 2 && !w && p) m_flush = m_flush + 32'd1;
    case (m_state)
      0: begin m_to = 0; if (w) m_state = 1; end
      1: begin
        if (!w) begin m_state = 0; m_to = 0; end
        else if (m_to == int'(MT) - 1) begin m_state = 2; m_to = 0; end
        else m_to = m_to + 1;
      end
      default: m_state = 2;
    endcase
    m_halt = (m_state == 2);
    @(posedge clk_i);
    #1;
    check_regs(tag);
  endtask

  task automatic check_in_reset(input string tag);
    check({tag, ".strobes"},  32'({ps, fs, ds, es, fb, db, mb}),         32'(7'b0000_111));
    check({tag, ".strobes4"}, 32'({ps4, fs4, ds4, es4, fb4, db4, mb4}), 32'(7'b0000_111));
    check_regs(tag);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    #1;
    check_in_reset("reset");
    @(negedge clk_i);
    rst = 1'b0;
    @(posedge clk_i);
    #1;

    // load-use on rs2, then same with x0 destination
    ld = 1'b1; need = 1'b1; dst = 5'd5; rs2 = 5'd5; use2 = 1'b1; rs1 = 5'd3; use1 = 1'b1;
    cycle("lu_rs2");
    idle(); cycle("lu_after");
    ld = 1'b1; need = 1'b1; dst = 5'd0; rs2 = 5'd0; use2 = 1'b1;
    cycle("lu_x0");
    idle();
    ld = 1'b1; need = 1'b1; dst = 5'd9; rs1 = 5'd9; use1 = 1'b0; rs2 = 5'd9; use2 = 1'b0;
    cycle("lu_nouse");
    use1 = 1'b1; cycle("lu_rs1");
    idle(); cycle("idle0");

    // mispredict alone, then with a load-use present
    misp = 1'b1; cycle("mp");
    idle(); cycle("mp_after");
    misp = 1'b1; ld = 1'b1; need = 1'b1; dst = 5'd7; rs1 = 5'd7; use1 = 1'b1;
    cycle("mp_lu");
    idle(); cycle("idle1");

    // 4-cycle memory wait then ready
    req = 1'b1; rdy = 1'b0;
    for (int i = 0; i < 4; i++) cycle("mw4");
    rdy = 1'b1; cycle("mw_ready");
    idle(); cycle("idle2");

    // mispredict deferred across a 3-cycle wait
    req = 1'b1; rdy = 1'b0; misp = 1'b1;
    for (int i = 0; i < 3; i++) cycle("mw_mp");
    rdy = 1'b1; cycle("mp_deferred");
    idle(); cycle("idle3");

    // memory timeout, sticky halt
    req = 1'b1; rdy = 1'b0;
    for (int i = 0; i < int'(MT) + 2; i++) cycle("timeout");
    idle(); misp = 1'b1;
    for (int i = 0; i < 3; i++) cycle("halted");

    // asynchronous reset mid-cycle
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_in_reset("async_rst");
    @(negedge clk_i);
    rst = 1'b0;
    idle();
    @(posedge clk_i);
    #1;

    // 4-bit counter wrap via repeated load-use stalls
    ld = 1'b1; need = 1'b1; dst = 5'd12; rs2 = 5'd12; use2 = 1'b1;
    for (int i = 0; i < 17; i++) cycle("wrap");
    idle(); cycle("idle4");

    // random traffic
    for (int i = 0; i < 60; i++) begin
      rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
      dst = 5'($urandom_range(0, 3));
      use1 = 1'($urandom); use2 = 1'($urandom);
      ld = 1'($urandom); need = 1'($urandom);
      misp = ($urandom_range(0, 3) == 0);
      req = ($urandom_range(0, 3) == 0); rdy = 1'($urandom);
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central hazard and sequencing controller for the 5-register in-order pipeline: pc_reg (P), fetch_reg (F), decode_reg (D), execute_reg (E), memory_reg (M).
- Generates every stall/bubble strobe those registers consume: load-use interlock, branch-mispredict squash, memory-wait freeze.
- Runs a small FSM with a memory-timeout watchdog and keeps performance counters for stall and flush events.
- Drives decode_reg's D_stall_i/D_bubble_i directly.

Parameters:
- MEM_TIMEOUT, 256, cycles in MWAIT before declaring a hang.
- CNT_W, 32, width of each performance counter.
- TO_W, 9, width of the timeout counter; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clk_i  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- Dc_rs1_i  in  5  rs1 index of the instruction in decode (fetch_reg output).
- Dc_rs2_i  in  5  rs2 index of the instruction in decode.
- Dc_use_rs1_i  in  1  decode instruction reads rs1.
- Dc_use_rs2_i  in  1  decode instruction reads rs2.
- Ex_load_i  in  1  execute-stage instruction is a load (DD_load_op_o != 0).
- Ex_need_dstE_i  in  1  execute-stage instruction writes rd (DD_need_dstE_o).
- Ex_dstE_i  in  5  execute-stage rd (DD_dstE_o).
- Ex_mispredict_i  in  1  execute-stage branch resolved against its prediction.
- M_mem_req_i  in  1  memory stage has an outstanding data access.
- M_mem_ready_i  in  1  data memory completes the access this cycle.
- P_stall_o, F_stall_o, D_stall_o, E_stall_o  out  1 each  hold the register.
- F_bubble_o, D_bubble_o, M_bubble_o  out  1 each  load a nop into the register.
- halt_o  out  1  pipeline frozen after a memory timeout; sticky.
- stall_cnt_o  out  CNT_W  cycles in which P_stall_o was high.
- flush_cnt_o  out  CNT_W  count of mispredict squashes.

Behaviour:
- Strobe outputs are combinational from the FSM state and current inputs. Counters, FSM state and halt_o are registered.
- While rst is high: F_bubble_o = D_bubble_o = M_bubble_o = 1, all stalls = 0, FSM = RUN, counters = 0, halt_o = 0.
- Hazard terms:
  - mw = M_mem_req_i & ~M_mem_ready_i.
  - lu = Ex_load_i & Ex_need_dstE_i & (Ex_dstE_i != 0) & ((Dc_use_rs1_i & Dc_rs1_i == Ex_dstE_i) | (Dc_use_rs2_i & Dc_rs2_i == Ex_dstE_i)).
  - mp = Ex_mispredict_i.
- Priority, highest first: HALT state > mw > mp > lu > none.
  - HALT: P, F, D, E stalls = 1; M_bubble_o = 1.
  - mw: P, F, D, E stalls = 1; M_bubble_o = 1. Writeback sees nops; the access is held in execute_reg.
  - mp: F_bubble_o = D_bubble_o = 1; P not stalled, so it loads the redirect. The lu term is ignored because the consumer is squashed.
  - lu: P_stall_o = F_stall_o = 1, D_bubble_o = 1, for exactly 1 cycle. Forwarding from memory covers the following cycle.
  - none: all strobes 0.
- A mispredict coinciding with mw is deferred. Execute is held, so Ex_mispredict_i persists and is serviced on the first cycle mw is low.
- FSM:
  - RUN -> MWAIT when mw.
  - MWAIT -> RUN when ~mw. The timeout counter clears.
  - MWAIT -> HALT when the counter reaches MEM_TIMEOUT - 1 with mw still high.
  - HALT is left only by reset; halt_o = 1 in HALT.
- Timeout counter: increments each cycle in MWAIT, clears in RUN.
- Counters:
  - stall_cnt_o += 1 on each cycle with P_stall_o = 1, including HALT.
  - flush_cnt_o += 1 on each cycle with the mp action taken.
  - Both wrap modulo 2^CNT_W with no saturation.
- Reset mid-MWAIT returns to RUN with the counter at 0; any in-flight access is abandoned.

Decomposition:
- define.v gains:
  - FSM state encodings: PC_RUN = 2'd0, PC_MWAIT = 2'd1, PC_HALT = 2'd2.
  - The default value for MEM_TIMEOUT.
- One natural sub-module: hazard_detect, the purely combinational lu/mw/mp terms. The FSM and counters stay in pipe_ctrl.

Test Plan:
1. Load to x5 in execute, decode reads rs2=5 with use_rs2=1 -> one cycle of P_stall=F_stall=D_bubble=1, then all 0; stall_cnt=1. Repeat with Ex_dstE=0 -> no stall.
2. Ex_mispredict=1 for 1 cycle -> F_bubble=D_bubble=1, P_stall=0; flush_cnt=1. The same stimulus with lu also true -> mispredict action only.
3. M_mem_req=1, ready low 4 cycles then high -> P/F/D/E stall and M_bubble for 4 cycles, FSM returns to RUN, stall_cnt=4.
4. Mispredict asserted during a 3-cycle mw -> no bubbles during the wait; F/D bubble on the first cycle after ready.
5. MEM_TIMEOUT=8, ready never rises -> halt_o=1 after 8 MWAIT cycles and stays 1. Async rst pulse mid-cycle -> halt_o=0, counters 0, bubbles 1 immediately.
6. Preload stall_cnt to 2^CNT_W-1 (CNT_W=4 build), one stall cycle -> stall_cnt wraps to 0.
